// File: rtl/credit_pkg.sv
// credit_pkg: constants and sizing helpers shared by both ends of the credit link.
package credit_pkg;

    localparam int unsigned CREDIT_DEPTH = 8;
    localparam int unsigned CREDIT_WIDTH = 16;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int unsigned credit_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [$clog2(CREDIT_DEPTH + 1)-1:0] credit_cnt_t;

endpackage

// File: rtl/credit_fifo_mem.sv
// credit_fifo_mem: DEPTH x WIDTH storage with one write port and an
// asynchronous read of the head entry. Contents are not reset.
module credit_fifo_mem
    import credit_pkg::*;
#(
    parameter int unsigned WIDTH = CREDIT_WIDTH,
    parameter int unsigned DEPTH = CREDIT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: single word per cycle at the write pointer.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/credit_rx_fifo.sv
// credit_rx_fifo: receive side of a credit link. Buffers pushed words in a
// DEPTH-entry FIFO, presents them on a req/ack port, and returns one credit
// per freed slot plus DEPTH initial credits after reset.
// Optional macro CREDIT_RX_OVF_CHECK_EN compiles in the sticky overflow flag.
module credit_rx_fifo
    import credit_pkg::*;
#(
    parameter int unsigned WIDTH = CREDIT_WIDTH,
    parameter int unsigned DEPTH = CREDIT_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             link_valid_i,
    input  logic [WIDTH-1:0] link_data_bi,
    output logic             link_credit_o,
    output logic             ext_dataout_genfifo_req_o,
    output logic [WIDTH-1:0] ext_dataout_genfifo_wdata_bo,
    input  logic             ext_dataout_genfifo_ack_i,
    output logic             overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = credit_cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_pending;

    logic             w_req;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_credit;
    logic [WIDTH-1:0] w_head;

    // Handshake qualifiers; everything is forced idle while reset is held.
    assign w_req    = (r_count != '0) & ~rst_i;
    assign w_pop    = w_req & ext_dataout_genfifo_ack_i;
    assign w_full   = (r_count == FULL_CNT);
    // A push into a full FIFO is only legal when a pop frees the slot this cycle.
    assign w_push   = link_valid_i & ~rst_i & ~(w_full & ~w_pop);
    assign w_credit = (r_pending != '0) & ~rst_i;

    // Pointer, occupancy and credit-backlog state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= FULL_CNT;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_pending <= r_pending + CW'(w_pop) - CW'(w_credit);
        end
    end

    credit_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (w_push),
        .waddr_i (r_wr_ptr),
        .wdata_i (link_data_bi),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_head)
    );

    assign ext_dataout_genfifo_req_o    = w_req;
    assign ext_dataout_genfifo_wdata_bo = w_req ? w_head : '0;
    assign link_credit_o                = w_credit;

`ifdef CREDIT_RX_OVF_CHECK_EN
    logic r_overflow;
    logic w_ovf_push;

    assign w_ovf_push = link_valid_i & ~rst_i & w_full & ~w_pop;

    // Sticky protocol-error flag: set on the first dropped push, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_push) begin
            r_overflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Report the offending cycle in simulation.
    always_ff @(posedge clk_i) begin
        if (w_ovf_push) begin
            $error("credit_rx_fifo: push into full FIFO dropped at %0t", $time);
        end
    end
`endif

    assign overflow_o = r_overflow;
`else
    assign overflow_o = 1'b0;
`endif

endmodule
